// File: rtl/video_acc_pkg.sv
// Shared video-accelerator types, lane counts and the RGBX8888 -> RGB565 conversion.
// Build option: RGB565_ROUND_EN selects round-to-nearest with saturation instead of truncation.
package video_acc_pkg;

    localparam int unsigned PIX_PER_IN_BEAT   = 2;
    localparam int unsigned PIX_PER_OUT_BEAT  = 4;
    localparam int unsigned STREAM_ID_WIDTH   = 4;
    localparam int unsigned STREAM_USER_WIDTH = 1;

    // Red lives in the least significant byte of each 32-bit pixel
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgbx8888_t;

    typedef struct packed {
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
    } rgb565_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    function automatic rgb565_t rgbx_to_565(input rgbx8888_t p);
        rgb565_t o;
`ifdef RGB565_ROUND_EN
        logic [8:0] sr;
        logic [8:0] sg;
        logic [8:0] sb;
        sr   = 9'(p.r) + 9'd4;
        sg   = 9'(p.g) + 9'd2;
        sb   = 9'(p.b) + 9'd4;
        // Bit 8 set means the rounded value overflows the narrow field
        o.r5 = sr[8] ? 5'd31 : 5'(sr >> 3);
        o.g6 = sg[8] ? 6'd63 : 6'(sg >> 2);
        o.b5 = sb[8] ? 5'd31 : 5'(sb >> 3);
`else
        o.r5 = p.r[7:3];
        o.g6 = p.g[7:2];
        o.b5 = p.b[7:3];
`endif
        return o;
    endfunction

endpackage

// File: rtl/rgb565_packer_if.sv
// Stream channel carrying data, byte qualifiers and side-band routing fields.
interface nasti_stream_channel
    import video_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEST_WIDTH = 3,
    parameter int unsigned ID_WIDTH   = STREAM_ID_WIDTH,
    parameter int unsigned USER_WIDTH = STREAM_USER_WIDTH
);
    logic                    t_valid;
    logic                    t_ready;
    logic [DATA_WIDTH-1:0]   t_data;
    logic [DATA_WIDTH/8-1:0] t_keep;
    logic [DATA_WIDTH/8-1:0] t_strb;
    logic                    t_last;
    logic [DEST_WIDTH-1:0]   t_dest;
    logic [ID_WIDTH-1:0]     t_id;
    logic [USER_WIDTH-1:0]   t_user;

    modport master (
        output t_valid, t_data, t_keep, t_strb, t_last, t_dest, t_id, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_keep, t_strb, t_last, t_dest, t_id, t_user,
        output t_ready
    );
endinterface

// File: rtl/rgb565_conv.sv
// Combinational single-pixel RGBX8888 -> RGB565 converter lane.
module rgb565_conv
    import video_acc_pkg::*;
(
    input  rgbx8888_t pix,
    output rgb565_t   px_c
);
    logic unused_alpha;

    assign px_c         = rgbx_to_565(pix);
    assign unused_alpha = ^pix.x;
endmodule

// File: rtl/rgb565_packer.sv
// Packs pairs of RGBX8888 beats into one RGB565 beat of four pixels; odd tails emit a half beat.
// Build option: RGB565_ROUND_EN (see video_acc_pkg) changes only the pixel conversion.
module rgb565_packer
    import video_acc_pkg::*;
#(
    parameter int unsigned DEST_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 64
)(
    input  logic                aclk,
    input  logic                aresetn,
    nasti_stream_channel.slave  src,
    nasti_stream_channel.master dst
);
    localparam int unsigned HALF_WIDTH = DATA_WIDTH / 2;

    if (DATA_WIDTH != 64) begin : g_bad_width
        $error("rgb565_packer supports only DATA_WIDTH = 64");
    end

    pack_state_t                            state_q;
    pack_state_t                            state_d;
    logic                                   accept;
    logic [PIX_PER_IN_BEAT-1:0][15:0]       pix565;
    logic [HALF_WIDTH-1:0]                  packed_c;

    logic [HALF_WIDTH-1:0]                  acc_data;
    logic [DEST_WIDTH-1:0]                  acc_dest;
    logic [STREAM_ID_WIDTH-1:0]             acc_id;
    logic [STREAM_USER_WIDTH-1:0]           acc_user;

    logic                                   load_acc;
    logic                                   load_out;
    logic [DATA_WIDTH-1:0]                  nxt_data;
    logic [DATA_WIDTH/8-1:0]                nxt_keep;
    logic                                   nxt_last;
    logic [DEST_WIDTH-1:0]                  nxt_dest;
    logic [STREAM_ID_WIDTH-1:0]             nxt_id;
    logic [STREAM_USER_WIDTH-1:0]           nxt_user;
    logic                                   unused_qual;

    for (genvar p = 0; p < PIX_PER_IN_BEAT; p++) begin : g_lane
        rgb565_conv u_conv (
            .pix  (src.t_data[32*p +: 32]),
            .px_c (pix565[p])
        );
    end

    assign packed_c    = pix565;
    assign src.t_ready = !dst.t_valid || dst.t_ready;
    assign accept      = src.t_valid && src.t_ready;
    assign unused_qual = ^{src.t_keep, src.t_strb};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    // Next state plus what to load into the accumulator / output register
    always_comb begin
        state_d  = state_q;
        load_acc = 1'b0;
        load_out = 1'b0;
        nxt_data = '0;
        nxt_keep = '0;
        nxt_last = 1'b0;
        nxt_dest = src.t_dest;
        nxt_id   = src.t_id;
        nxt_user = src.t_user;
        if (accept) begin
            case (state_q)
                EMPTY: begin
                    if (src.t_last) begin
                        load_out = 1'b1;
                        nxt_data = {HALF_WIDTH'(0), packed_c};
                        nxt_keep = 8'h0F;
                        nxt_last = 1'b1;
                    end else begin
                        load_acc = 1'b1;
                        state_d  = HALF;
                    end
                end
                HALF: begin
                    load_out = 1'b1;
                    nxt_data = {packed_c, acc_data};
                    nxt_keep = 8'hFF;
                    nxt_last = src.t_last;
                    nxt_dest = acc_dest;
                    nxt_id   = acc_id;
                    nxt_user = acc_user;
                    state_d  = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_data <= '0;
            acc_dest <= '0;
            acc_id   <= '0;
            acc_user <= '0;
        end else if (load_acc) begin
            acc_data <= packed_c;
            acc_dest <= src.t_dest;
            acc_id   <= src.t_id;
            acc_user <= src.t_user;
        end
    end

    // Single output stage; reloads in the same cycle it drains
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dst.t_valid <= 1'b0;
            dst.t_data  <= '0;
            dst.t_keep  <= '0;
            dst.t_strb  <= '0;
            dst.t_last  <= 1'b0;
            dst.t_dest  <= '0;
            dst.t_id    <= '0;
            dst.t_user  <= '0;
        end else if (load_out) begin
            dst.t_valid <= 1'b1;
            dst.t_data  <= nxt_data;
            dst.t_keep  <= nxt_keep;
            dst.t_strb  <= nxt_keep;
            dst.t_last  <= nxt_last;
            dst.t_dest  <= nxt_dest;
            dst.t_id    <= nxt_id;
            dst.t_user  <= nxt_user;
        end else if (dst.t_ready) begin
            dst.t_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rgb565_packer.sv
// Directed scoreboard bench for rgb565_packer; expected beats are queued on accept and checked on output.
module tb_rgb565_packer;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [2:0]  dest;
        logic [3:0]  id;
        logic        user;
    } exp_t;

    logic aclk = 1'b0;
    logic aresetn;
    int   vectors     = 0;
    int   miscompares = 0;
    int   out_count   = 0;
    exp_t sb[$];

    logic        have_half;
    logic [31:0] h_data;
    logic [2:0]  h_dest;
    logic [3:0]  h_id;
    logic        h_user;
    logic        stall_prev;
    logic [63:0] held_data;

    nasti_stream_channel #(.DATA_WIDTH(64), .DEST_WIDTH(3)) s_if ();
    nasti_stream_channel #(.DATA_WIDTH(64), .DEST_WIDTH(3)) d_if ();

    rgb565_packer #(.DEST_WIDTH(3), .DATA_WIDTH(64)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .src     (s_if),
        .dst     (d_if)
    );

    always #5 aclk = ~aclk;

    function automatic logic [15:0] ref565(input logic [31:0] p);
        int r, g, b;
        r = int'(p[7:0]);
        g = int'(p[15:8]);
        b = int'(p[23:16]);
`ifdef RGB565_ROUND_EN
        r = (r + 4) / 8; if (r > 31) r = 31;
        g = (g + 2) / 4; if (g > 63) g = 63;
        b = (b + 4) / 8; if (b > 31) b = 31;
`else
        r = r / 8;
        g = g / 4;
        b = b / 8;
`endif
        return {5'(r), 6'(g), 5'(b)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pop on every handshake, and watch data stability while stalled
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && d_if.t_valid)
                chk("stall_hold", 128'(d_if.t_data), 128'(held_data));
            if (d_if.t_valid && d_if.t_ready) begin
                out_count++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", 128'(d_if.t_data), 128'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_beat", 128'({d_if.t_data, d_if.t_keep, d_if.t_last, d_if.t_dest,
                                          d_if.t_id, d_if.t_user}), 128'(e));
                    chk("out_strb", 128'(d_if.t_strb), 128'(e.keep));
                end
            end
            stall_prev = d_if.t_valid && !d_if.t_ready;
            held_data  = d_if.t_data;
        end
    end

    task automatic send(input logic [63:0] d, input logic l, input logic [2:0] de, input logic [3:0] id);
        int          n;
        logic        acc;
        logic        u;
        logic [31:0] pk;
        u = ^d;
        s_if.t_valid = 1'b1;
        s_if.t_data  = d;
        s_if.t_keep  = 8'($urandom);
        s_if.t_strb  = 8'($urandom);
        s_if.t_last  = l;
        s_if.t_dest  = de;
        s_if.t_id    = id;
        s_if.t_user  = u;
        n = 0;
        do begin
            @(negedge aclk);
            acc = s_if.t_ready;
            n++;
            @(posedge aclk);
            #1;
        end while (!acc && n < 200);
        s_if.t_valid = 1'b0;
        if (!acc) begin
            chk("src_accept_timeout", 128'(acc), 128'(1));
            return;
        end
        pk = {ref565(d[63:32]), ref565(d[31:0])};
        if (!have_half) begin
            if (l) sb.push_back('{{32'h0, pk}, 8'h0F, 1'b1, de, id, u});
            else begin
                have_half = 1'b1; h_data = pk; h_dest = de; h_id = id; h_user = u;
            end
        end else begin
            sb.push_back('{{pk, h_data}, 8'hFF, l, h_dest, h_id, h_user});
            have_half = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge aclk);
            n++;
        end
        repeat (2) @(posedge aclk);
        #1;
        chk("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    task automatic chk_dst_zero(input string tag);
        chk(tag, 128'({d_if.t_valid, d_if.t_data, d_if.t_keep, d_if.t_strb, d_if.t_last,
                       d_if.t_dest, d_if.t_id, d_if.t_user}), 128'(0));
    endtask

    initial begin
        int base;
        have_half    = 1'b0;
        aresetn      = 1'b0;
        s_if.t_valid = 1'b0;
        s_if.t_data  = '0;
        s_if.t_keep  = '0;
        s_if.t_strb  = '0;
        s_if.t_last  = 1'b0;
        s_if.t_dest  = '0;
        s_if.t_id    = '0;
        s_if.t_user  = '0;
        d_if.t_ready = 1'b1;
        repeat (2) @(negedge aclk);
        chk_dst_zero("reset_state");
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Basic packing and one-cycle output latency
        send(64'h00FFFFFF_000080FF, 1'b0, 3'd2, 4'd0);
        chk("valid_before_pair", 128'(d_if.t_valid), 128'(0));
        send(64'h00000000_00FF0000, 1'b1, 3'd0, 4'd0);
        chk("valid_after_pair", 128'(d_if.t_valid), 128'(1));
        chk("pack_data", 128'(d_if.t_data), 128'(64'h0000_001F_FFFF_FC00));
        chk("pack_keep_last_dest", 128'({d_if.t_keep, d_if.t_last, d_if.t_dest}),
            128'({8'hFF, 1'b1, 3'd2}));
        drain();

        // Odd tail: one last beat alone
        send(64'h00FFFFFF_000080FF, 1'b1, 3'd4, 4'd1);
        chk("tail_data", 128'(d_if.t_data), 128'(64'h0000_0000_FFFF_FC00));
        chk("tail_keep", 128'({d_if.t_keep, d_if.t_last}), 128'({8'h0F, 1'b1}));
        drain();

        // Side-band comes from the first beat
        send(64'h11223344_55667788, 1'b0, 3'd1, 4'd3);
        send(64'h99AABBCC_DDEEFF00, 1'b1, 3'd5, 4'd9);
        chk("sideband", 128'({d_if.t_dest, d_if.t_id}), 128'({3'd1, 4'd3}));
        drain();

        // Rounding and saturation corner pixels
        send(64'h00040307_00040307, 1'b0, 3'd0, 4'd2);
        send(64'h00040307_00040307, 1'b1, 3'd0, 4'd2);
`ifdef RGB565_ROUND_EN
        chk("round_data", 128'(d_if.t_data), 128'(64'h0821_0821_0821_0821));
`else
        chk("trunc_data", 128'(d_if.t_data), 128'(64'h0));
`endif
        send(64'h00FFFFFF_00FFFFFF, 1'b1, 3'd0, 4'd0);
        chk("sat_data", 128'(d_if.t_data), 128'(64'h0000_0000_FFFF_FFFF));
        drain();

        // Backpressure: sink stalled for 10 cycles
        base = out_count;
        d_if.t_ready = 1'b0;
        fork
            begin
                repeat (10) @(posedge aclk);
                #1;
                d_if.t_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) begin
            send({32'($urandom), 32'($urandom)}, 1'(i == 7), 3'(i), 4'(i));
            if (i == 1) chk("src_ready_drop", 128'(s_if.t_ready), 128'(0));
        end
        drain();
        chk("bp_out_count", 128'(out_count - base), 128'(4));

        // Reset with a half-filled accumulator
        send(64'hDEADBEEF_CAFEF00D, 1'b0, 3'd6, 4'd6);
        aresetn   = 1'b0;
        have_half = 1'b0;
        @(negedge aclk);
        chk_dst_zero("mid_reset_zero");
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk_dst_zero("post_reset_idle");
        send(64'h0000FF00_000000FF, 1'b0, 3'd3, 4'd4);
        send(64'h00FF00FF_00FFFF00, 1'b1, 3'd0, 4'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
